// File: rtl/fetch_queue_stage_if.sv
// Fetch-stage bus: EX redirect inputs, IF/ID handshake and the debug fetch PC.
// master = fetch stage, slave = consumer (IF/ID register / bench).
interface fetch_queue_stage_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] fetch_pc;

  modport master (
    input  redirect_valid, redirect_pc, if_ready,
    output if_valid, if_instr, if_pc, fetch_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, if_ready,
    input  if_valid, if_instr, if_pc, fetch_pc
  );
endinterface

// File: rtl/fetch_queue_stage.sv
// RV32I fetch stage: PC, synchronous-read imem, 2-entry fetch queue with redirect flush.
// Optional FETCH_PERF_CNT_EN adds saturating perf_fetched / perf_bubbles counters.
module fetch_queue_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter int unsigned IMEM_AW    = 10
) (
  input  logic                clk,
  input  logic                rst,
  fetch_queue_stage_if.master fq
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_bubbles
`endif
);

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic {RUN, HOLD} state_t;

  state_t      state, state_d;
  logic [31:0] mem [0:IMEM_DEPTH-1];

  logic [31:0] pc;
  logic [31:0] q_instr [0:1];
  logic [31:0] q_pc    [0:1];
  logic [1:0]  count;
  logic        inflight;
  logic [31:0] inflight_pc;
  logic [31:0] rdata;

  logic        pop;
  logic        push;
  logic        issue;
  logic        tail;
  logic [1:0]  occ;

  // A redirect cycle never hands off the head: it is a flushed instruction.
  assign fq.if_valid = (count != 2'd0) & ~fq.redirect_valid;
  assign fq.if_instr = (count != 2'd0) ? q_instr[0] : NOP;
  assign fq.if_pc    = (count != 2'd0) ? q_pc[0]    : '0;
  assign fq.fetch_pc = pc;

  always_comb begin
    pop     = fq.if_valid & fq.if_ready;
    push    = inflight & ~fq.redirect_valid;
    occ     = count + {1'b0, inflight} - {1'b0, pop};
    tail    = (count == 2'd2) | ((count == 2'd1) & ~pop);
    issue   = 1'b0;
    state_d = state;
    if (fq.redirect_valid) begin
      state_d = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (occ < 2'd2) issue = 1'b1;
          else            state_d = HOLD;
        end
        // HOLD implies a full queue and nothing in flight, so only a pop frees a slot.
        HOLD: begin
          if (pop) begin
            issue   = 1'b1;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      pc       <= RESET_PC;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      state <= state_d;
      if (fq.redirect_valid) begin
        pc       <= {fq.redirect_pc[31:2], 2'b00};
        count    <= '0;
        inflight <= 1'b0;
      end else begin
        // Without a redirect push == inflight, so the new count is exactly occ.
        count    <= occ;
        inflight <= issue;
        if (issue) pc <= pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      q_instr[0] <= q_instr[1];
      q_pc[0]    <= q_pc[1];
    end
    if (push) begin
      q_instr[tail] <= rdata;
      q_pc[tail]    <= inflight_pc;
    end
    if (issue) begin
      rdata       <= mem[pc[IMEM_AW+1:2]];
      inflight_pc <= pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (pop && (perf_fetched != '1))
        perf_fetched <= perf_fetched + 32'd1;
      if (fq.if_ready && !fq.if_valid && (perf_bubbles != '1))
        perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

  push_into_full: assert property (@(posedge clk) disable iff (rst)
    !(push && (count == 2'd2) && !pop));

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Self-checking bench for fetch_queue_stage: queue-based reference model plus directed literals.
module tb_fetch_queue_stage;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [31:0] memv [0:1023];

  fetch_queue_stage_if bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  fetch_queue_stage #(
    .RESET_PC  (32'h0),
    .IMEM_DEPTH(1024),
    .IMEM_AW   (10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fq (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_bubbles(perf_bubbles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: fetch stream as a pending read plus a FIFO of {pc, instr}.
  logic [31:0] m_pc;
  logic [31:0] mq_pc [$];
  logic [31:0] mq_in [$];
  bit          m_pend;
  logic [31:0] m_pend_pc;
  int unsigned m_fetched;
  int unsigned m_bubbles;

  always @(posedge clk) begin
    int occ;
    bit vld;
    bit pop;
    vld = (mq_pc.size() > 0) && !bus.redirect_valid;
    pop = vld && bus.if_ready;
    if (rst) begin
      m_pc = 32'h0;
      mq_pc.delete();
      mq_in.delete();
      m_pend    = 1'b0;
      m_fetched = 0;
      m_bubbles = 0;
    end else begin
      if (pop) m_fetched++;
      if (bus.if_ready && !vld) m_bubbles++;
      if (bus.redirect_valid) begin
        mq_pc.delete();
        mq_in.delete();
        m_pend = 1'b0;
        m_pc   = {bus.redirect_pc[31:2], 2'b00};
      end else begin
        occ = mq_pc.size() + (m_pend ? 1 : 0) - (pop ? 1 : 0);
        if (pop) begin
          void'(mq_pc.pop_front());
          void'(mq_in.pop_front());
        end
        if (m_pend) begin
          mq_pc.push_back(m_pend_pc);
          mq_in.push_back(memv[m_pend_pc[11:2]]);
        end
        if (occ < 2) begin
          m_pend    = 1'b1;
          m_pend_pc = m_pc;
          m_pc      = m_pc + 32'd4;
        end else begin
          m_pend = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
    ev = (mq_pc.size() > 0) && !bus.redirect_valid;
    ei = (mq_pc.size() > 0) ? mq_in[0] : 32'h00000013;
    ep = (mq_pc.size() > 0) ? mq_pc[0] : 32'h0;
    chk("model_if_valid", {31'd0, bus.if_valid}, {31'd0, ev});
    chk("model_if_instr", bus.if_instr, ei);
    chk("model_if_pc", bus.if_pc, ep);
    chk("model_fetch_pc", bus.fetch_pc, m_pc);
`ifdef FETCH_PERF_CNT_EN
    chk("model_perf_fetched", perf_fetched, m_fetched);
    chk("model_perf_bubbles", perf_bubbles, m_bubbles);
`endif
  end

  initial begin
    logic [39:0] rp;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.if_ready       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    for (int i = 0; i < 1024; i++) memv[i] = 32'h1000_0000 + i;
    memv[0] = 32'h00000013;
    memv[1] = 32'h00100093;
    memv[2] = 32'h00200113;
    memv[3] = 32'h00002183;
    for (int i = 0; i < 1024; i++) dut.mem[i] = memv[i];

    // Reset and stream
    @(negedge clk);
    chk("rst_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("rst_instr", bus.if_instr, 32'h00000013);
    chk("rst_pc", bus.if_pc, 32'h0);
    chk("rst_fetch_pc", bus.fetch_pc, 32'h0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t1_latency", {31'd0, bus.if_valid}, 32'd0);
    @(negedge clk);
    chk("t1_v0", {31'd0, bus.if_valid}, 32'd1);
    chk("t1_pc0", bus.if_pc, 32'h0);
    chk("t1_i0", bus.if_instr, 32'h00000013);
    @(negedge clk);
    chk("t1_pc4", bus.if_pc, 32'h4);
    chk("t1_i4", bus.if_instr, 32'h00100093);
    @(negedge clk);
    chk("t1_pc8", bus.if_pc, 32'h8);
    chk("t1_i8", bus.if_instr, 32'h00200113);
    @(negedge clk);
    chk("t1_pc12", bus.if_pc, 32'hC);
    chk("t1_i12", bus.if_instr, 32'h00002183);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched_lit", perf_fetched, 32'd3);
    chk("perf_bubbles_lit", perf_bubbles, 32'd2);
`endif

    // Stall hold at head 0x10
    @(negedge clk);
    chk("t2_head", bus.if_pc, 32'h10);
    #1 bus.if_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("t2_hold_pc", bus.if_pc, 32'h10);
      chk("t2_hold_instr", bus.if_instr, 32'h1000_0004);
      chk("t2_hold_fetch_pc", bus.fetch_pc, 32'h18);
    end
    #1 bus.if_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t2_release_pc", bus.if_pc, 32'h14 + 32'(4 * k));
    end

    // Branch flush with 0x20/0x24 queued; low target bits ignored
    @(negedge clk);
    chk("t3_head20", bus.if_pc, 32'h20);
    #1 bus.if_ready = 1'b0;
    @(negedge clk);
    chk("t3_still20", bus.if_pc, 32'h20);
    #1;
    bus.if_ready       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h2B;
    #1 chk("t3_gate", {31'd0, bus.if_valid}, 32'd0);
    @(negedge clk);
    chk("t3_flush_v", {31'd0, bus.if_valid}, 32'd0);
    #1 bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("t3_issue_v", {31'd0, bus.if_valid}, 32'd0);
    @(negedge clk);
    chk("t3_target_v", {31'd0, bus.if_valid}, 32'd1);
    chk("t3_target_pc", bus.if_pc, 32'h28);
    chk("t3_target_i", bus.if_instr, 32'h1000_000A);

    // Redirect during stall
    #1;
    bus.if_ready       = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h50;
    @(negedge clk);
    chk("t4_flush_v", {31'd0, bus.if_valid}, 32'd0);
    #1 bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("t4_issue_v", {31'd0, bus.if_valid}, 32'd0);
    @(negedge clk);
    chk("t4_head", bus.if_pc, 32'h50);
    @(negedge clk);
    chk("t4_hold_pc", bus.if_pc, 32'h50);
    chk("t4_hold_i", bus.if_instr, 32'h1000_0014);
    chk("t4_fetch_pc", bus.fetch_pc, 32'h58);
    #1 bus.if_ready = 1'b1;
    @(negedge clk);
    chk("t4_next", bus.if_pc, 32'h54);

    // Imem index wrap
    #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFC;
    @(negedge clk);
    #1 bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("t5_wait", {31'd0, bus.if_valid}, 32'd0);
    @(negedge clk);
    chk("t5_pc_ffc", bus.if_pc, 32'hFFC);
    chk("t5_i_last", bus.if_instr, 32'h1000_03FF);
    @(negedge clk);
    chk("t5_pc_1000", bus.if_pc, 32'h1000);
    chk("t5_i_first", bus.if_instr, 32'h00000013);

    // 32-bit PC wrap
    #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk);
    #1 bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("t5b_wait", {31'd0, bus.if_valid}, 32'd0);
    @(negedge clk);
    chk("t5b_pc_top", bus.if_pc, 32'hFFFF_FFFC);
    chk("t5b_i_top", bus.if_instr, 32'h1000_03FF);
    chk("t5b_fetch_pc", bus.fetch_pc, 32'h4);
    @(negedge clk);
    chk("t5b_pc_zero", bus.if_pc, 32'h0);
    chk("t5b_i_zero", bus.if_instr, 32'h00000013);

    // Mid-stream reset
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t5c_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("t5c_instr", bus.if_instr, 32'h00000013);
    chk("t5c_pc", bus.if_pc, 32'h0);
    chk("t5c_fetch_pc", bus.fetch_pc, 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5c_lat", {31'd0, bus.if_valid}, 32'd0);
    @(negedge clk);
    chk("t5c_restart_v", {31'd0, bus.if_valid}, 32'd1);
    chk("t5c_restart_pc", bus.if_pc, 32'h0);

    // Mixed stalls with a redirect, checked by the model only
    rp = 40'hF3_A596_C37E;
    for (int i = 0; i < 40; i++) begin
      #1;
      bus.if_ready       = rp[i];
      bus.redirect_valid = (i == 20);
      bus.redirect_pc    = 32'h100;
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
